// File: rtl/ball_motion_if.sv
// Ball engine bus: per-frame strobe, serve and paddle position in; ball position and status out.
interface ball_motion_if;
  logic       frame_start;
  logic       serve;
  logic [9:0] paddle_x;
  logic [9:0] paddle_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       in_play;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] hit_count;
  logic [7:0] miss_count;

  modport master (
    output frame_start, serve, paddle_x, paddle_y,
    input  ball_x, ball_y, in_play, hit_pulse, miss_pulse, hit_count, miss_count
  );

  modport slave (
    input  frame_start, serve, paddle_x, paddle_y,
    output ball_x, ball_y, in_play, hit_pulse, miss_pulse, hit_count, miss_count
  );
endinterface

// File: rtl/ball_motion.sv
// Frame-rate ball physics: wall/paddle bounces, miss detection, hit/miss counters, timed re-serve.
// Optional BALL_SPEEDUP_EN: each paddle hit raises speed by one, capped at MAX_SPEED.
module ball_motion #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned BALL_SIZE   = 8,
  parameter int unsigned PADDLE_W    = 8,
  parameter int unsigned PADDLE_H    = 64,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned MAX_SPEED   = 6,
  parameter int unsigned SERVE_DELAY = 60
) (
  input logic          clk,
  input logic          reset_n,
  ball_motion_if.slave bus
);
  localparam int unsigned XW    = 10;
  localparam int unsigned CW    = 8;
  localparam int unsigned PW    = 12;
  localparam int unsigned SPMAX = (MAX_SPEED > SPEED) ? MAX_SPEED : SPEED;
  localparam int unsigned SW    = $clog2(SPMAX + 1);
  localparam int unsigned TW    = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [XW-1:0] X_MAX = XW'(SCREEN_W - BALL_SIZE);
  localparam logic [XW-1:0] Y_MAX = XW'(SCREEN_H - BALL_SIZE);
  localparam logic [XW-1:0] X_CTR = XW'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [XW-1:0] Y_CTR = XW'((SCREEN_H - BALL_SIZE) / 2);

  localparam logic signed [PW-1:0] ZERO_S  = '0;
  localparam logic signed [PW-1:0] X_MAX_S = PW'(SCREEN_W - BALL_SIZE);
  localparam logic signed [PW-1:0] Y_MAX_S = PW'(SCREEN_H - BALL_SIZE);
  localparam logic signed [PW-1:0] BALL_S  = PW'(BALL_SIZE);
  localparam logic signed [PW-1:0] PAD_W_S = PW'(PADDLE_W);
  localparam logic signed [PW-1:0] PAD_H_S = PW'(PADDLE_H);

  localparam logic [SW-1:0] SPEED_INIT = SW'(SPEED);
  localparam logic [TW-1:0] TMR_LOAD   = TW'(SERVE_DELAY - 1);
`ifdef BALL_SPEEDUP_EN
  localparam logic [SW-1:0] SPEED_TOP  = SW'(MAX_SPEED);
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_PLAY, ST_MISS} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] bx_q, bx_d, by_q, by_d;
  logic          dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [SW-1:0] speed_q, speed_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          in_play_q, in_play_d;
  logic          hit_q, hit_d, miss_q, miss_d;
  logic [CW-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic signed [PW-1:0] bx_s, by_s, spd_s, nx, ny, px_s, py_s, px_end;
  logic                 hit_c, miss_c;

  // Candidate position and paddle geometry in signed 12-bit space, so nothing wraps at 10 bits
  assign bx_s   = $signed(PW'(bx_q));
  assign by_s   = $signed(PW'(by_q));
  assign spd_s  = $signed(PW'(speed_q));
  assign px_s   = $signed(PW'(bus.paddle_x));
  assign py_s   = $signed(PW'(bus.paddle_y));
  assign nx     = dx_neg_q ? (bx_s - spd_s) : (bx_s + spd_s);
  assign ny     = dy_neg_q ? (by_s - spd_s) : (by_s + spd_s);
  assign px_end = px_s + PAD_W_S;

  assign hit_c  = dx_neg_q && (nx <= px_end) && ((nx + BALL_S) > px_s) &&
                  ((by_s + BALL_S) > py_s) && (by_s < (py_s + PAD_H_S));
  assign miss_c = dx_neg_q && (nx <= ZERO_S);

  always_comb begin
    state_d    = state_q;
    bx_d       = bx_q;
    by_d       = by_q;
    dx_neg_d   = dx_neg_q;
    dy_neg_d   = dy_neg_q;
    speed_d    = speed_q;
    timer_d    = timer_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bus.frame_start) begin
      unique case (state_q)
        ST_IDLE: begin
          bx_d = X_CTR;
          by_d = Y_CTR;
          if (bus.serve) begin
            state_d = ST_SERVE;
            timer_d = TMR_LOAD;
          end
        end
        ST_SERVE: begin
          bx_d = X_CTR;
          by_d = Y_CTR;
          if (timer_q == '0) begin
            state_d  = ST_PLAY;
            dx_neg_d = 1'b0;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_PLAY: begin
          // Vertical and horizontal outcomes are independent so a corner applies both
          if (ny <= ZERO_S) begin
            by_d     = '0;
            dy_neg_d = 1'b0;
          end else if (ny >= Y_MAX_S) begin
            by_d     = Y_MAX;
            dy_neg_d = 1'b1;
          end else begin
            by_d = XW'(ny);
          end
          if (nx >= X_MAX_S) begin
            bx_d     = X_MAX;
            dx_neg_d = 1'b1;
          end else if (hit_c) begin
            bx_d     = (px_end > X_MAX_S) ? X_MAX : XW'(px_end);
            dx_neg_d = 1'b0;
            hit_d    = 1'b1;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
`ifdef BALL_SPEEDUP_EN
            if (speed_q < SPEED_TOP) speed_d = speed_q + 1'b1;
`endif
          end else if (miss_c) begin
            bx_d    = '0;
            state_d = ST_MISS;
            miss_d  = 1'b1;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
          end else begin
            bx_d = XW'(nx);
          end
        end
        ST_MISS: begin
          state_d  = ST_SERVE;
          timer_d  = TMR_LOAD;
          bx_d     = X_CTR;
          by_d     = Y_CTR;
          dy_neg_d = ~dy_neg_q;
          speed_d  = SPEED_INIT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    in_play_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bx_q       <= X_CTR;
      by_q       <= Y_CTR;
      dx_neg_q   <= 1'b0;
      dy_neg_q   <= 1'b0;
      speed_q    <= SPEED_INIT;
      timer_q    <= '0;
      in_play_q  <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      dx_neg_q   <= dx_neg_d;
      dy_neg_q   <= dy_neg_d;
      speed_q    <= speed_d;
      timer_q    <= timer_d;
      in_play_q  <= in_play_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.ball_x     = bx_q;
  assign bus.ball_y     = by_q;
  assign bus.in_play    = in_play_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: table of serve/motion steps, directed wall/paddle/miss/reset/saturation runs,
// and randomized play, all scored against a velocity-based reference model.
module tb_ball_motion;
  localparam int BALL = 8, PADW = 8, PADH = 64, SPEED = 2, MAX_SPEED = 6, SERVE_DELAY = 60;
  localparam int XMAX = 632, YMAX = 472, XC = 316, YC = 236;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_MISS = 3;
`ifdef BALL_SPEEDUP_EN
  localparam int SP1 = 3;
`else
  localparam int SP1 = 2;
`endif

  typedef struct {
    int nfr;
    bit srv;
    int px;
    int py;
    int ex;
    int ey;
    bit eplay;
    int ehits;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  ball_motion_if bus ();

  ball_motion dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #20 clk = ~clk;

  int checks, errors;
  int m_st, m_x, m_y, m_dx, m_dy, m_spd, m_tmr, m_hits, m_misses, m_hit_events;
  bit m_hitp, m_missp;
  bit last_hit, last_miss;
  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_x = XC; m_y = YC; m_dx = SPEED; m_dy = SPEED; m_spd = SPEED;
    m_tmr = 0; m_hits = 0; m_misses = 0; m_hit_events = 0; m_hitp = 0; m_missp = 0;
  endtask

  // Reference: signed velocities, plain integer arithmetic
  task automatic model_frame(input bit srv, input int px, input int py);
    int nx, ny, s;
    bit hit;
    m_hitp = 0;
    m_missp = 0;
    case (m_st)
      M_IDLE: if (srv) begin m_st = M_SERVE; m_tmr = SERVE_DELAY - 1; end
      M_SERVE: begin
        if (m_tmr == 0) begin m_st = M_PLAY; m_dx = m_spd; end
        else m_tmr--;
      end
      M_PLAY: begin
        nx = m_x + m_dx;
        ny = m_y + m_dy;
        hit = (m_dx < 0) && (nx <= px + PADW) && (nx + BALL > px) && (m_y + BALL > py) && (m_y < py + PADH);
        if (hit) begin
          m_hitp = 1;
          m_hit_events++;
          if (m_hits < 255) m_hits++;
`ifdef BALL_SPEEDUP_EN
          if (m_spd < MAX_SPEED) m_spd++;
`endif
        end
        s = m_spd;
        m_dy = (m_dy < 0) ? -s : s;
        if (ny <= 0) begin m_y = 0; m_dy = s; end
        else if (ny >= YMAX) begin m_y = YMAX; m_dy = -s; end
        else m_y = ny;
        if (nx >= XMAX) begin m_x = XMAX; m_dx = -s; end
        else if (hit) begin m_x = (px + PADW > XMAX) ? XMAX : px + PADW; m_dx = s; end
        else if (m_dx < 0 && nx <= 0) begin
          m_x = 0; m_st = M_MISS; m_missp = 1;
          if (m_misses < 255) m_misses++;
        end else m_x = nx;
      end
      default: begin
        m_st = M_SERVE; m_tmr = SERVE_DELAY - 1; m_x = XC; m_y = YC;
        m_dy = (m_dy < 0) ? SPEED : -SPEED; m_spd = SPEED;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s.ball_x", tag), int'(bus.ball_x), m_x);
    chk($sformatf("%s.ball_y", tag), int'(bus.ball_y), m_y);
    chk($sformatf("%s.in_play", tag), int'(bus.in_play), (m_st == M_PLAY) ? 1 : 0);
    chk($sformatf("%s.hit_pulse", tag), int'(bus.hit_pulse), int'(m_hitp));
    chk($sformatf("%s.miss_pulse", tag), int'(bus.miss_pulse), int'(m_missp));
    chk($sformatf("%s.hit_count", tag), int'(bus.hit_count), m_hits);
    chk($sformatf("%s.miss_count", tag), int'(bus.miss_count), m_misses);
  endtask

  // One frame: strobe, check registered result, then a quiet cycle where pulses must be low
  task automatic frame(input bit srv, input int px, input int py);
    bus.serve = srv;
    bus.paddle_x = 10'(px);
    bus.paddle_y = 10'(py);
    bus.frame_start = 1'b1;
    @(posedge clk);
    model_frame(srv, px, py);
    @(negedge clk);
    bus.frame_start = 1'b0;
    last_hit = bus.hit_pulse;
    last_miss = bus.miss_pulse;
    check_all("frame");
    @(negedge clk);
    m_hitp = 0;
    m_missp = 0;
    check_all("quiet");
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit found;
    checks = 0;
    errors = 0;
    tbl[0] = '{1,  1'b0, 0, 0, XC,  YC,  1'b0, 0};
    tbl[1] = '{1,  1'b1, 0, 0, XC,  YC,  1'b0, 0};
    tbl[2] = '{59, 1'b1, 0, 0, XC,  YC,  1'b0, 0};
    tbl[3] = '{1,  1'b1, 0, 0, XC,  YC,  1'b1, 0};
    tbl[4] = '{1,  1'b1, 0, 0, 318, 238, 1'b1, 0};
    tbl[5] = '{10, 1'b1, 0, 0, 338, 258, 1'b1, 0};

    reset_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.serve = 1'b0;
    bus.paddle_x = '0;
    bus.paddle_y = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      repeat (tbl[i].nfr) frame(tbl[i].srv, tbl[i].px, tbl[i].py);
      chk($sformatf("tbl%0d.ball_x", i), int'(bus.ball_x), tbl[i].ex);
      chk($sformatf("tbl%0d.ball_y", i), int'(bus.ball_y), tbl[i].ey);
      chk($sformatf("tbl%0d.in_play", i), int'(bus.in_play), int'(tbl[i].eplay));
      chk($sformatf("tbl%0d.hit_count", i), int'(bus.hit_count), tbl[i].ehits);
    end

    // Bottom wall, then right wall, then first step back
    repeat (107) frame(1'b0, 0, 0);
    chk("bottom.ball_x", int'(bus.ball_x), 552);
    chk("bottom.ball_y", int'(bus.ball_y), 472);
    repeat (40) frame(1'b0, 0, 0);
    chk("right.ball_x", int'(bus.ball_x), 632);
    chk("right.ball_y", int'(bus.ball_y), 392);
    frame(1'b0, 0, 0);
    chk("rebound.ball_x", int'(bus.ball_x), 630);
    chk("rebound.ball_y", int'(bus.ball_y), 390);

    // Top wall on the way to a paddle at (16,200)
    repeat (302) frame(1'b0, 16, 200);
    chk("pre_hit.ball_x", int'(bus.ball_x), 26);
    chk("pre_hit.ball_y", int'(bus.ball_y), 214);
    frame(1'b0, 16, 200);
    chk("hit.ball_x", int'(bus.ball_x), 24);
    chk("hit.ball_y", int'(bus.ball_y), 216);
    chk("hit.pulse", int'(last_hit), 1);
    chk("hit.count", int'(bus.hit_count), 1);
    frame(1'b0, 16, 200);
    chk("post_hit.ball_x", int'(bus.ball_x), 24 + SP1);
    chk("post_hit.ball_y", int'(bus.ball_y), 216 + SP1);
    chk("post_hit.pulse", int'(last_hit), 0);

    // Miss: keep the paddle vertically clear of the ball
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      frame(1'b0, 16, (m_y < 240) ? 400 : 0);
      if (m_st == M_MISS) found = 1;
    end
    if (!found) timeout_fail("miss_wait");
    chk("miss.ball_x", int'(bus.ball_x), 0);
    chk("miss.pulse", int'(last_miss), 1);
    chk("miss.count", int'(bus.miss_count), 1);
    chk("miss.in_play", int'(bus.in_play), 0);
    frame(1'b0, 16, 0);
    chk("reserve.ball_x", int'(bus.ball_x), XC);
    chk("reserve.ball_y", int'(bus.ball_y), YC);
    chk("reserve.in_play", int'(bus.in_play), 0);

    // Randomized play: mostly a tracking paddle near the left edge, sometimes a stray one
    for (int i = 0; i < 1500; i++) begin
      int px, py;
      px = int'($urandom_range(0, 40));
      if ($urandom_range(0, 3) != 0) py = m_y - int'($urandom_range(0, 60));
      else py = int'($urandom_range(0, 1023));
      if (py < 0) py = 0;
      frame(1'($urandom_range(0, 1)), px, py);
    end

    // Reset while in PLAY
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_st == M_PLAY) found = 1;
      else frame(1'b0, 0, 0);
    end
    if (!found) timeout_fail("play_wait");
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("midreset");
    chk("midreset.ball_x", int'(bus.ball_x), XC);
    chk("midreset.in_play", int'(bus.in_play), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Re-serve, then rally against a paddle just left of the right wall until the counter saturates
    frame(1'b1, 0, 0);
    repeat (SERVE_DELAY) frame(1'b0, 0, 0);
    chk("serve2.in_play", int'(bus.in_play), 1);
    found = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      int py;
      py = m_y - 28;
      if (py < 0) py = 0;
      frame(1'b0, 616, py);
      if (m_hit_events >= 260) found = 1;
    end
    if (!found) timeout_fail("saturation_wait");
    chk("saturate.hit_count", int'(bus.hit_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
